// File: rtl/regfile_pkg.sv
// Shared defaults and width helpers for the scoreboarded register file.
// AW/CW are derived here so top and scoreboard always agree on widths.
package regfile_pkg;

   localparam int DEF_WIDTH = 32;
   localparam int DEF_DEPTH = 32;
   localparam int DEF_NRD   = 2;

   function automatic int clog2(input int n);
      int r;
      r = 0;
      while ((1 << r) < n) r++;
      return r;
   endfunction

   function automatic int addr_width(input int depth);
      return clog2(depth);
   endfunction

   // One extra code so the counter can hold DEPTH itself.
   function automatic int cnt_width(input int depth);
      return clog2(depth + 1);
   endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register busy scoreboard: tracks issued-but-not-written destinations,
// produces the issue handshake and a running count of pending writes.
module regfile_scoreboard
   import regfile_pkg::*;
#(
   parameter int DEPTH = DEF_DEPTH,
   parameter int AW    = addr_width(DEF_DEPTH),
   parameter int CW    = cnt_width(DEF_DEPTH)
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             wr_ok,
   input  logic [AW-1:0]    wr_addr,
   input  logic             iss_trk,
   input  logic             iss_acc,
   input  logic [AW-1:0]    iss_addr,
   output logic [DEPTH-1:0] busy,
   output logic             iss_ready,
   output logic [CW-1:0]    pend_cnt
);

   logic [DEPTH-1:0] set_vec;
   logic [DEPTH-1:0] clr_vec;
   logic             inc;
   logic             dec;

   // Untracked destinations (zero register, out of range) are always accepted.
   assign iss_ready = !iss_trk || !busy[iss_addr] || (wr_ok && (wr_addr == iss_addr));

   // NOTE: every signal written in always_comb gets a default first, otherwise a latch is inferred.
   always_comb begin
      set_vec = '0;
      clr_vec = '0;
      if (iss_acc && iss_trk) set_vec[iss_addr] = 1'b1;
      if (wr_ok)              clr_vec[wr_addr]  = 1'b1;
   end

   // Issue wins over a same-address writeback, so a bit only drops if not re-set.
   assign inc = |(set_vec & ~busy);
   assign dec = |(clr_vec & busy & ~set_vec);

   // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         busy     <= '0;
         pend_cnt <= '0;
      end else begin
         busy     <= (busy & ~clr_vec) | set_vec;
         pend_cnt <= pend_cnt + CW'(inc) - CW'(dec);
      end
   end

endmodule

// File: rtl/regfile_sb.sv
// Parametrised multi-read register file with optional zero register,
// write-to-read bypass and a busy scoreboard for RAW/WAW hazard detection.
module regfile_sb
   import regfile_pkg::*;
#(
   parameter  int WIDTH    = DEF_WIDTH,
   parameter  int DEPTH    = DEF_DEPTH,
   parameter  int NRD      = DEF_NRD,
   parameter  int ZERO_REG = 1,
   parameter  int BYPASS   = 1,
   localparam int AW       = addr_width(DEPTH),
   localparam int CW       = cnt_width(DEPTH)
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic [NRD*AW-1:0]    rd_addr,
   output logic [NRD*WIDTH-1:0] rd_data,
   output logic [NRD-1:0]       rd_busy,
   input  logic                 wr_en,
   input  logic [AW-1:0]        wr_addr,
   input  logic [WIDTH-1:0]     wr_data,
   input  logic                 iss_en,
   input  logic [AW-1:0]        iss_addr,
   output logic                 iss_ready,
   output logic [CW-1:0]        pend_cnt
);

   localparam logic [AW:0] DEPTH_V = (AW+1)'(DEPTH);

   function automatic logic in_range(input logic [AW-1:0] a);
      return {1'b0, a} < DEPTH_V;
   endfunction

   function automatic logic writable(input logic [AW-1:0] a);
      return in_range(a) && !((ZERO_REG != 0) && (a == '0));
   endfunction

   logic [WIDTH-1:0] mem [DEPTH];
   logic [DEPTH-1:0] busy;
   logic             wr_ok;
   logic             iss_trk;
   logic             iss_acc;

   assign wr_ok   = wr_en && writable(wr_addr);
   assign iss_trk = writable(iss_addr);
   assign iss_acc = iss_en && iss_ready;

   // NOTE: the storage array is reset explicitly because software may read any register before writing it.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else if (wr_ok) begin
         mem[wr_addr] <= wr_data;
      end
   end

   regfile_scoreboard #(
      .DEPTH (DEPTH),
      .AW    (AW),
      .CW    (CW)
   ) u_sb (
      .clock     (clock),
      .reset     (reset),
      .wr_ok     (wr_ok),
      .wr_addr   (wr_addr),
      .iss_trk   (iss_trk),
      .iss_acc   (iss_acc),
      .iss_addr  (iss_addr),
      .busy      (busy),
      .iss_ready (iss_ready),
      .pend_cnt  (pend_cnt)
   );

   // The zero register is never written or marked busy, so a plain lookup already reads 0.
   always_comb begin
      rd_data = '0;
      rd_busy = '0;
      for (int i = 0; i < NRD; i++) begin
         if (in_range(rd_addr[i*AW +: AW])) begin
            rd_data[i*WIDTH +: WIDTH] = mem[rd_addr[i*AW +: AW]];
            rd_busy[i]                = busy[rd_addr[i*AW +: AW]];
         end
         if ((BYPASS != 0) && wr_ok && (wr_addr == rd_addr[i*AW +: AW])) begin
            rd_data[i*WIDTH +: WIDTH] = wr_data;
            rd_busy[i]                = 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_regfile_sb.sv
// Self-checking bench for regfile_sb: directed scenarios on three configurations
// plus randomized traffic against an array-based reference model.
module tb_regfile_sb;

   logic clock = 1'b0;
   logic reset = 1'b0;
   int   checks = 0;
   int   errors = 0;

   always #5 clock = ~clock;

   // dut_a: defaults (32x32, NRD=2, BYPASS=1)
   logic [9:0]  a_rd_addr = '0;
   logic [63:0] a_rd_data;
   logic [1:0]  a_rd_busy;
   logic        a_wr_en = 1'b0;
   logic [4:0]  a_wr_addr = '0;
   logic [31:0] a_wr_data = '0;
   logic        a_iss_en = 1'b0;
   logic [4:0]  a_iss_addr = '0;
   logic        a_iss_ready;
   logic [5:0]  a_pend_cnt;

   // dut_b: BYPASS=0
   logic [9:0]  b_rd_addr = '0;
   logic [63:0] b_rd_data;
   logic [1:0]  b_rd_busy;
   logic        b_wr_en = 1'b0;
   logic [4:0]  b_wr_addr = '0;
   logic [31:0] b_wr_data = '0;
   logic        b_iss_en = 1'b0;
   logic [4:0]  b_iss_addr = '0;
   logic        b_iss_ready;
   logic [5:0]  b_pend_cnt;

   // dut_c: DEPTH=20, NRD=3
   logic [14:0] c_rd_addr = '0;
   logic [95:0] c_rd_data;
   logic [2:0]  c_rd_busy;
   logic        c_wr_en = 1'b0;
   logic [4:0]  c_wr_addr = '0;
   logic [31:0] c_wr_data = '0;
   logic        c_iss_en = 1'b0;
   logic [4:0]  c_iss_addr = '0;
   logic        c_iss_ready;
   logic [4:0]  c_pend_cnt;

   regfile_sb dut_a (
      .clock(clock), .reset(reset), .rd_addr(a_rd_addr), .rd_data(a_rd_data),
      .rd_busy(a_rd_busy), .wr_en(a_wr_en), .wr_addr(a_wr_addr), .wr_data(a_wr_data),
      .iss_en(a_iss_en), .iss_addr(a_iss_addr), .iss_ready(a_iss_ready), .pend_cnt(a_pend_cnt)
   );

   regfile_sb #(.BYPASS(0)) dut_b (
      .clock(clock), .reset(reset), .rd_addr(b_rd_addr), .rd_data(b_rd_data),
      .rd_busy(b_rd_busy), .wr_en(b_wr_en), .wr_addr(b_wr_addr), .wr_data(b_wr_data),
      .iss_en(b_iss_en), .iss_addr(b_iss_addr), .iss_ready(b_iss_ready), .pend_cnt(b_pend_cnt)
   );

   regfile_sb #(.DEPTH(20), .NRD(3)) dut_c (
      .clock(clock), .reset(reset), .rd_addr(c_rd_addr), .rd_data(c_rd_data),
      .rd_busy(c_rd_busy), .wr_en(c_wr_en), .wr_addr(c_wr_addr), .wr_data(c_wr_data),
      .iss_en(c_iss_en), .iss_addr(c_iss_addr), .iss_ready(c_iss_ready), .pend_cnt(c_pend_cnt)
   );

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b0;
      repeat (3) tick();
      checks++; if (a_rd_data !== 64'd0) begin errors++; $display("FAIL reset_rd_data: got %0h want 0", a_rd_data); end
      checks++; if (a_rd_busy !== 2'b00) begin errors++; $display("FAIL reset_rd_busy: got %b want 00", a_rd_busy); end
      checks++; if (a_iss_ready !== 1'b1) begin errors++; $display("FAIL reset_iss_ready: got %b want 1", a_iss_ready); end
      checks++; if (a_pend_cnt !== 6'd0) begin errors++; $display("FAIL reset_pend_cnt: got %0d want 0", a_pend_cnt); end
      checks++; if (c_pend_cnt !== 5'd0) begin errors++; $display("FAIL reset_pend_cnt_c: got %0d want 0", c_pend_cnt); end
      reset = 1'b1;
      tick();
   endtask

   task automatic test_write();
      a_wr_en = 1'b1; a_wr_addr = 5'd31; a_wr_data = 32'd3098;
      tick();
      a_wr_en = 1'b0; a_rd_addr = {5'd31, 5'd0};
      #1;
      checks++; if (a_rd_data[63:32] !== 32'd3098) begin errors++; $display("FAIL write_first: got %0d want 3098", a_rd_data[63:32]); end
      a_wr_en = 1'b1; a_wr_data = 32'd9912;
      tick();
      a_wr_en = 1'b0;
      #1;
      checks++; if (a_rd_data[63:32] !== 32'd9912) begin errors++; $display("FAIL write_second: got %0d want 9912", a_rd_data[63:32]); end
      a_iss_en = 1'b1; a_iss_addr = 5'd2;
      tick();
      a_iss_en = 1'b0;
      checks++; if (a_pend_cnt !== 6'd1) begin errors++; $display("FAIL pre_reset_pend: got %0d want 1", a_pend_cnt); end
      reset = 1'b0;
      #1;
      checks++; if (a_rd_data[63:32] !== 32'd0) begin errors++; $display("FAIL async_reset_data: got %0d want 0", a_rd_data[63:32]); end
      checks++; if (a_pend_cnt !== 6'd0) begin errors++; $display("FAIL async_reset_pend: got %0d want 0", a_pend_cnt); end
      reset = 1'b1;
      tick();
   endtask

   task automatic test_zero();
      a_wr_en = 1'b1; a_wr_addr = 5'd0; a_wr_data = 32'hDEADBEEF;
      a_iss_en = 1'b1; a_iss_addr = 5'd0; a_rd_addr = 10'd0;
      #1;
      checks++; if (a_iss_ready !== 1'b1) begin errors++; $display("FAIL zero_iss_ready: got %b want 1", a_iss_ready); end
      checks++; if (a_rd_data[31:0] !== 32'd0) begin errors++; $display("FAIL zero_bypass: got %0h want 0", a_rd_data[31:0]); end
      tick();
      a_wr_en = 1'b0; a_iss_en = 1'b0;
      #1;
      checks++; if (a_rd_data[31:0] !== 32'd0) begin errors++; $display("FAIL zero_data: got %0h want 0", a_rd_data[31:0]); end
      checks++; if (a_rd_busy[0] !== 1'b0) begin errors++; $display("FAIL zero_busy: got %b want 0", a_rd_busy[0]); end
      checks++; if (a_pend_cnt !== 6'd0) begin errors++; $display("FAIL zero_pend: got %0d want 0", a_pend_cnt); end
   endtask

   task automatic test_bypass();
      a_wr_en = 1'b1; a_wr_addr = 5'd5; a_wr_data = 32'd7;
      b_wr_en = 1'b1; b_wr_addr = 5'd5; b_wr_data = 32'd7;
      tick();
      a_wr_data = 32'd42; b_wr_data = 32'd42;
      a_rd_addr = {5'd0, 5'd5}; b_rd_addr = {5'd0, 5'd5};
      #1;
      checks++; if (a_rd_data[31:0] !== 32'd42) begin errors++; $display("FAIL bypass_on_data: got %0d want 42", a_rd_data[31:0]); end
      checks++; if (a_rd_busy[0] !== 1'b0) begin errors++; $display("FAIL bypass_on_busy: got %b want 0", a_rd_busy[0]); end
      checks++; if (b_rd_data[31:0] !== 32'd7) begin errors++; $display("FAIL bypass_off_before: got %0d want 7", b_rd_data[31:0]); end
      tick();
      a_wr_en = 1'b0; b_wr_en = 1'b0;
      #1;
      checks++; if (b_rd_data[31:0] !== 32'd42) begin errors++; $display("FAIL bypass_off_after: got %0d want 42", b_rd_data[31:0]); end
      checks++; if (a_rd_data[31:0] !== 32'd42) begin errors++; $display("FAIL bypass_on_after: got %0d want 42", a_rd_data[31:0]); end
   endtask

   task automatic test_scoreboard();
      a_iss_en = 1'b1; a_iss_addr = 5'd3;
      #1;
      checks++; if (a_iss_ready !== 1'b1) begin errors++; $display("FAIL sb_first_ready: got %b want 1", a_iss_ready); end
      tick();
      a_iss_en = 1'b0; a_rd_addr = {5'd3, 5'd0};
      #1;
      checks++; if (a_rd_busy[1] !== 1'b1) begin errors++; $display("FAIL sb_busy_set: got %b want 1", a_rd_busy[1]); end
      checks++; if (a_pend_cnt !== 6'd1) begin errors++; $display("FAIL sb_pend_one: got %0d want 1", a_pend_cnt); end
      a_iss_en = 1'b1;
      #1;
      checks++; if (a_iss_ready !== 1'b0) begin errors++; $display("FAIL sb_stall_ready: got %b want 0", a_iss_ready); end
      tick();
      a_iss_en = 1'b0;
      #1;
      checks++; if (a_rd_busy[1] !== 1'b1) begin errors++; $display("FAIL sb_stall_busy: got %b want 1", a_rd_busy[1]); end
      checks++; if (a_pend_cnt !== 6'd1) begin errors++; $display("FAIL sb_stall_pend: got %0d want 1", a_pend_cnt); end
      a_wr_en = 1'b1; a_wr_addr = 5'd3; a_wr_data = 32'd11;
      tick();
      a_wr_en = 1'b0;
      #1;
      checks++; if (a_rd_busy[1] !== 1'b0) begin errors++; $display("FAIL sb_wb_busy: got %b want 0", a_rd_busy[1]); end
      checks++; if (a_pend_cnt !== 6'd0) begin errors++; $display("FAIL sb_wb_pend: got %0d want 0", a_pend_cnt); end
      checks++; if (a_rd_data[63:32] !== 32'd11) begin errors++; $display("FAIL sb_wb_data: got %0d want 11", a_rd_data[63:32]); end
   endtask

   task automatic test_same_addr();
      a_iss_en = 1'b1; a_iss_addr = 5'd7;
      tick();
      a_wr_en = 1'b1; a_wr_addr = 5'd7; a_wr_data = 32'h77;
      #1;
      checks++; if (a_iss_ready !== 1'b1) begin errors++; $display("FAIL same_ready: got %b want 1", a_iss_ready); end
      tick();
      a_wr_en = 1'b0; a_iss_en = 1'b0; a_rd_addr = {5'd7, 5'd0};
      #1;
      checks++; if (a_rd_data[63:32] !== 32'h77) begin errors++; $display("FAIL same_data: got %0h want 77", a_rd_data[63:32]); end
      checks++; if (a_rd_busy[1] !== 1'b1) begin errors++; $display("FAIL same_busy: got %b want 1", a_rd_busy[1]); end
      checks++; if (a_pend_cnt !== 6'd1) begin errors++; $display("FAIL same_pend: got %0d want 1", a_pend_cnt); end
      a_wr_en = 1'b1; a_wr_data = 32'h78;
      tick();
      a_wr_en = 1'b0;
      #1;
      checks++; if (a_pend_cnt !== 6'd0) begin errors++; $display("FAIL same_cleanup: got %0d want 0", a_pend_cnt); end
   endtask

   task automatic test_fill_drain();
      logic [19:0] busy_m;
      logic [31:0] reg_m [20];
      busy_m = '0;
      for (int r = 1; r < 20; r++) begin
         c_iss_en = 1'b1; c_iss_addr = 5'(r);
         #1;
         checks++; if (c_iss_ready !== 1'b1) begin errors++; $display("FAIL fill_ready r%0d: got %b want 1", r, c_iss_ready); end
         tick();
         busy_m[r] = 1'b1;
         checks++; if (c_pend_cnt !== 5'($countones(busy_m))) begin errors++; $display("FAIL fill_popcount r%0d: got %0d want %0d", r, c_pend_cnt, $countones(busy_m)); end
      end
      checks++; if (c_pend_cnt !== 5'd19) begin errors++; $display("FAIL fill_full: got %0d want 19", c_pend_cnt); end
      c_iss_addr = 5'd25;
      #1;
      checks++; if (c_iss_ready !== 1'b1) begin errors++; $display("FAIL oor_ready: got %b want 1", c_iss_ready); end
      tick();
      c_iss_en = 1'b0; c_rd_addr = {5'd25, 5'd0, 5'd1};
      #1;
      checks++; if (c_pend_cnt !== 5'd19) begin errors++; $display("FAIL oor_pend: got %0d want 19", c_pend_cnt); end
      checks++; if (c_rd_data[95:64] !== 32'd0) begin errors++; $display("FAIL oor_data: got %0h want 0", c_rd_data[95:64]); end
      checks++; if (c_rd_busy !== 3'b001) begin errors++; $display("FAIL oor_busy: got %b want 001", c_rd_busy); end
      for (int r = 1; r < 20; r++) begin
         c_wr_en = 1'b1; c_wr_addr = 5'(r); c_wr_data = $urandom;
         reg_m[r] = c_wr_data;
         tick();
         busy_m[r] = 1'b0;
         checks++; if (c_pend_cnt !== 5'($countones(busy_m))) begin errors++; $display("FAIL drain_popcount r%0d: got %0d want %0d", r, c_pend_cnt, $countones(busy_m)); end
      end
      c_wr_en = 1'b0;
      for (int r = 1; r < 20; r++) begin
         c_rd_addr[(r % 3)*5 +: 5] = 5'(r);
         #1;
         checks++; if (c_rd_data[(r % 3)*32 +: 32] !== reg_m[r]) begin errors++; $display("FAIL drain_data r%0d: got %0h want %0h", r, c_rd_data[(r % 3)*32 +: 32], reg_m[r]); end
      end
      checks++; if (c_pend_cnt !== 5'd0) begin errors++; $display("FAIL drain_empty: got %0d want 0", c_pend_cnt); end
   endtask

   function automatic logic [4:0] pick_addr();
      return ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
   endfunction

   task automatic test_random();
      logic [31:0] reg_m [32];
      bit          busy_m [32];
      int          pend_m;
      logic [31:0] exp_d;
      logic        exp_b;
      logic        exp_r;
      logic [4:0]  ra;
      reset = 1'b0;
      #2;
      reset = 1'b1;
      for (int i = 0; i < 32; i++) begin reg_m[i] = '0; busy_m[i] = 1'b0; end
      tick();
      for (int n = 0; n < 300; n++) begin
         a_wr_en = ($urandom_range(0, 9) < 4); a_wr_addr = pick_addr(); a_wr_data = $urandom;
         a_iss_en = ($urandom_range(0, 9) < 6); a_iss_addr = pick_addr();
         a_rd_addr = {pick_addr(), pick_addr()};
         #1;
         for (int p = 0; p < 2; p++) begin
            ra = a_rd_addr[p*5 +: 5];
            if (ra == 0) begin
               exp_d = '0; exp_b = 1'b0;
            end else if (a_wr_en && a_wr_addr == ra) begin
               exp_d = a_wr_data; exp_b = 1'b0;
            end else begin
               exp_d = reg_m[ra]; exp_b = busy_m[ra];
            end
            checks++; if (a_rd_data[p*32 +: 32] !== exp_d) begin errors++; $display("FAIL rand_data n%0d p%0d r%0d: got %0h want %0h", n, p, ra, a_rd_data[p*32 +: 32], exp_d); end
            checks++; if (a_rd_busy[p] !== exp_b) begin errors++; $display("FAIL rand_busy n%0d p%0d r%0d: got %b want %b", n, p, ra, a_rd_busy[p], exp_b); end
         end
         exp_r = (a_iss_addr == 0) || !busy_m[a_iss_addr] || (a_wr_en && a_wr_addr == a_iss_addr);
         checks++; if (a_iss_ready !== exp_r) begin errors++; $display("FAIL rand_ready n%0d r%0d: got %b want %b", n, a_iss_addr, a_iss_ready, exp_r); end
         pend_m = 0;
         for (int i = 0; i < 32; i++) pend_m += int'(busy_m[i]);
         checks++; if (a_pend_cnt !== 6'(pend_m)) begin errors++; $display("FAIL rand_pend n%0d: got %0d want %0d", n, a_pend_cnt, pend_m); end
         if (a_wr_en && a_wr_addr != 0) begin
            reg_m[a_wr_addr]  = a_wr_data;
            busy_m[a_wr_addr] = 1'b0;
         end
         if (a_iss_en && exp_r && a_iss_addr != 0) busy_m[a_iss_addr] = 1'b1;
         tick();
      end
      a_wr_en = 1'b0; a_iss_en = 1'b0;
   endtask

   initial begin
      test_reset();
      test_write();
      test_zero();
      test_bypass();
      test_scoreboard();
      test_same_addr();
      test_fill_drain();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/regfile_sb.md
Name: regfile_sb

Overview:
- Parametrised successor to the single-write, dual-read 32x32 register file.
- Generalises width, depth and read-port count, and adds an optional hardwired zero register and write-to-read bypass.
- Adds a per-register busy scoreboard with an issue handshake and a pending-write counter, so the pipeline can detect RAW/WAW hazards.
- Sits between decode (reads, issue) and writeback (writes).

Parameters:
- WIDTH, 32, data bits per register
- DEPTH, 32, number of registers (>=2; need not be a power of two)
- NRD, 2, number of combinational read ports (1..4)
- ZERO_REG, 1, when 1, register 0 reads 0, ignores writes and is never busy
- BYPASS, 1, when 1, a same-cycle write is forwarded to matching read ports
- AW (localparam), clog2(DEPTH), address width
- CW (localparam), clog2(DEPTH+1), counter width

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- rd_addr  in  NRD*AW  packed read addresses; port i is at [i*AW +: AW]
- rd_data  out  NRD*WIDTH  packed read data
- rd_busy  out  NRD  busy flag of each read address
- wr_en  in  1  writeback enable
- wr_addr  in  AW  writeback address
- wr_data  in  WIDTH  writeback data
- iss_en  in  1  issue request: mark iss_addr as pending
- iss_addr  in  AW  destination being issued
- iss_ready  out  1  issue may be accepted this cycle
- pend_cnt  out  CW  number of busy registers

Behaviour:
- Reset (reset=0, asynchronous, takes effect immediately, also mid-operation):
  - all registers 0, all busy bits 0, pend_cnt 0.
  - Outputs are combinational, so during reset rd_data=0, rd_busy=0, iss_ready=1.
- Reads are combinational, zero latency.
  - rd_data[i] = reg[rd_addr[i]].
  - If BYPASS=1 and wr_en && wr_addr==rd_addr[i] (and the address is writable), rd_data[i] = wr_data.
- rd_busy[i] = busy[rd_addr[i]], with these exceptions:
  - When BYPASS=1, a same-cycle writeback to that address forces 0.
  - The zero register is always 0.
- Write: on the clock edge with wr_en=1, reg[wr_addr] <= wr_data and busy[wr_addr] <= 0.
  - Ignored for the zero register when ZERO_REG=1.
  - Ignored when wr_addr >= DEPTH.
- Writing a non-busy register is legal: the data updates and busy stays 0.
- Issue handshake:
  - iss_ready = !busy[iss_addr] || (wr_en && wr_addr==iss_addr). A pending writeback in the same cycle frees the slot.
  - Accept = iss_en && iss_ready. On the edge, busy[iss_addr] <= 1.
  - iss_en with iss_ready=0: no state change; the requester holds iss_en/iss_addr.
  - Issue to the zero register (ZERO_REG=1) or to an address >= DEPTH: iss_ready=1, accepted, no busy change.
- Simultaneous writeback and accepted issue to the same address: data is written and busy ends at 1 (issue wins).
- pend_cnt is a registered counter, updated on each edge:
  - +1 per accepted issue that sets a previously clear busy bit.
  - -1 per write that clears a set busy bit.
  - Same-address write+issue: net 0.
  - Range 0..DEPTH. pend_cnt always equals popcount(busy); the bench checks this.
- Out-of-range reads (rd_addr >= DEPTH) return rd_data=0 and rd_busy=0.
- All rd_addr ports are independent; any number may alias the same register.

Decomposition:
- Package regfile_pkg:
  - default WIDTH/DEPTH/NRD constants
  - clog2 function
  - AW/CW derivation helpers
- One sub-module, regfile_scoreboard:
  - busy vector, iss_ready logic, pend_cnt counter
  - inputs: wr_en/wr_addr, accepted issue, zero-register and range qualifiers
- Storage array and read/bypass muxing stay in regfile_sb.

Test Plan:
1. Reset then write: reset low for 3 cycles, then wr_en=1, wr_addr=31, wr_data=3098 -> after the edge, rd_addr[1]=31 gives rd_data=3098. A second write of 9912 -> reads 9912. Asserting reset low mid-run -> rd_data=0 immediately, without waiting for a clock edge.
2. Zero register: write 0xDEADBEEF to r0 and issue r0 -> rd_data=0, rd_busy=0, pend_cnt=0.
3. Bypass: with r5=7, drive wr_en=1, wr_addr=5, wr_data=42 and rd_addr[0]=5 in the same cycle -> rd_data[0]=42 and rd_busy[0]=0 before the edge. Repeat with BYPASS=0 -> 7 before the edge, 42 after.
4. Scoreboard:
   - issue r3 -> rd_busy=1, pend_cnt=1.
   - issue r3 again -> iss_ready=0; busy, pend_cnt and all state unchanged.
   - write r3=11 -> busy 0, pend_cnt=0.
5. Simultaneous write and issue to r7 (busy) -> iss_ready=1; after the edge r7 holds the new data, busy=1, pend_cnt unchanged.
6. Fill and drain with DEPTH=20, NRD=3:
   - issue r1..r19 -> pend_cnt=19.
   - issue r25 (out of range) -> accepted, pend_cnt stays 19, read of r25=0.
   - write all 19 back -> pend_cnt=0.
   - check pend_cnt == popcount(busy) every cycle throughout.
